psum_spad_ctrl: RTL

Sequencer for the PE's partial-sum scratchpad: clears a job's psum entries, runs read-modify-write accumulation of an incoming product stream, then drains the final psums to the output interface. It sits between the MAC output and the psum scratchpad. It drives the scratchpad's rd/wr/address/data pins and is the scratchpad's only master.

---
 rtl/psum_spad_ctrl.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/psum_spad_ctrl.sv
// psum_spad_ctrl: partial-sum scratchpad sequencer for one PE.
// A job runs in four phases:
//   1. CLEAR zeroes entries 0..N-1.
//   2. ACCUM performs a two-stage read-modify-write of the product stream.
//      The last write is forwarded, so back-to-back products to the same
//      entry accumulate correctly.
//   3. FLUSH waits one cycle so the final write commits.
//   4. DRAIN streams the N psums out with a valid/ready handshake.
// This block is the only master of the scratchpad.
module psum_spad_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   num_psum,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          addr_err,
  output logic          spad_rd,
  output logic          spad_wr,
  output logic [AW-1:0] spad_raddr,
  output logic [AW-1:0] spad_waddr,
  output logic [DW-1:0] spad_wdata,
  input  logic [DW-1:0] spad_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [AW:0] ZERO_W  = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  // Control registers.
  state_e        state_q;
  logic [AW:0]   n_q;
  logic [AW:0]   idx_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          addr_err_q;
  logic          rd_pending_q;
  logic [AW-1:0] rd_addr_q;
  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;
  logic          out_last_q;

  // Accumulation pipeline: stage 1 and the write-forwarding register.
  logic          s1_valid_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_data_q;
  logic          wq_valid_q;
  logic [AW-1:0] wq_addr_q;
  logic [DW-1:0] wq_data_q;

  // Combinational helpers.
  logic [AW:0]   n_start_s;
  logic          accept_s;
  logic          in_range_s;
  logic          fwd_s;
  logic [DW-1:0] operand_s;
  logic [DW-1:0] sum_s;
  logic          drain_rd_s;
  logic          out_fire_s;

  // Job size: 0 or anything above DEPTH means the full scratchpad.
  always_comb begin
    n_start_s = num_psum;
    if ((num_psum == ZERO_W) || (num_psum > DEPTH_W)) begin
      n_start_s = DEPTH_W;
    end else begin
      n_start_s = num_psum;
    end
  end

  assign accept_s   = (state_q == S_ACCUM) && in_ready_q && in_valid;
  assign in_range_s = ({1'b0, in_addr} < n_q);
  assign out_fire_s = out_valid_q && out_ready;

  // Pick the read operand. If the write issued last cycle hit this entry,
  // the read raced that write and returned stale data.
  always_comb begin
    fwd_s     = wq_valid_q && (wq_addr_q == s1_addr_q);
    operand_s = spad_rdata;
    if (fwd_s) begin
      operand_s = wq_data_q;
    end else begin
      operand_s = spad_rdata;
    end
    sum_s = operand_s + s1_data_q;
  end

  // Drain read: the first entry, or the next entry on the cycle the
  // current psum is handed off. Never while a capture is pending.
  always_comb begin
    drain_rd_s = 1'b0;
    if ((state_q == S_DRAIN) && (idx_q < n_q) && !rd_pending_q &&
        (!out_valid_q || out_ready)) begin
      drain_rd_s = 1'b1;
    end else begin
      drain_rd_s = 1'b0;
    end
  end

  // Scratchpad read port.
  // Drain reads and accumulation reads never overlap because they
  // belong to different states. Reset masks every access in that cycle.
  always_comb begin
    spad_rd    = 1'b0;
    spad_raddr = {AW{1'b0}};
    if (rst) begin
      spad_rd    = 1'b0;
      spad_raddr = {AW{1'b0}};
    end else if (drain_rd_s) begin
      spad_rd    = 1'b1;
      spad_raddr = idx_q[AW-1:0];
    end else if (accept_s && in_range_s) begin
      spad_rd    = 1'b1;
      spad_raddr = in_addr;
    end else begin
      spad_rd    = 1'b0;
      spad_raddr = {AW{1'b0}};
    end
  end

  // Scratchpad write port: zero fill during CLEAR, or the stage-1 sum.
  always_comb begin
    spad_wr    = 1'b0;
    spad_waddr = {AW{1'b0}};
    spad_wdata = {DW{1'b0}};
    if (rst) begin
      spad_wr    = 1'b0;
      spad_waddr = {AW{1'b0}};
      spad_wdata = {DW{1'b0}};
    end else if (state_q == S_CLEAR) begin
      spad_wr    = 1'b1;
      spad_waddr = idx_q[AW-1:0];
      spad_wdata = {DW{1'b0}};
    end else if (s1_valid_q) begin
      spad_wr    = 1'b1;
      spad_waddr = s1_addr_q;
      spad_wdata = sum_s;
    end else begin
      spad_wr    = 1'b0;
      spad_waddr = {AW{1'b0}};
      spad_wdata = {DW{1'b0}};
    end
  end

  // Accumulation pipeline: register accepted in-range products, then keep
  // the last write so the next stage-1 entry can forward it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= {AW{1'b0}};
      s1_data_q  <= {DW{1'b0}};
      wq_valid_q <= 1'b0;
      wq_addr_q  <= {AW{1'b0}};
      wq_data_q  <= {DW{1'b0}};
    end else begin
      s1_valid_q <= accept_s && in_range_s;
      if (accept_s) begin
        s1_addr_q <= in_addr;
        s1_data_q <= in_data;
      end
      wq_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        wq_addr_q <= s1_addr_q;
        wq_data_q <= sum_s;
      end
    end
  end

  // Job sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= ZERO_W;
      idx_q        <= ZERO_W;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= {AW{1'b0}};
      out_valid_q  <= 1'b0;
      out_addr_q   <= {AW{1'b0}};
      out_data_q   <= {DW{1'b0}};
      out_last_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q        <= n_start_s;
            idx_q      <= ZERO_W;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (idx_q == (n_q - ONE_W)) begin
            idx_q      <= ZERO_W;
            in_ready_q <= 1'b1;
            state_q    <= S_ACCUM;
          end else begin
            idx_q <= idx_q + ONE_W;
          end
        end
        S_ACCUM: begin
          if (accept_s) begin
            if (!in_range_s) begin
              addr_err_q <= 1'b1;
            end
            if (in_last) begin
              in_ready_q <= 1'b0;
            end
          end
          // The product accepted with in_last writes in this cycle,
          // so stage 1 is empty at this edge.
          if (!in_ready_q) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          idx_q        <= ZERO_W;
          rd_pending_q <= 1'b0;
          state_q      <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_rd_s) begin
            idx_q        <= idx_q + ONE_W;
            rd_addr_q    <= idx_q[AW-1:0];
            rd_pending_q <= 1'b1;
          end else begin
            rd_pending_q <= 1'b0;
          end
          if (rd_pending_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= spad_rdata;
            out_addr_q  <= rd_addr_q;
            out_last_q  <= (idx_q == n_q);
          end else if (out_fire_s) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
